// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Holds the controller state encoding and the bubble control word used by the stage registers.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    typedef struct packed {
        logic                      reg_we;
        logic                      mem_rd;
        logic                      mem_wr;
        logic                      branch;
        logic [REG_ADDR_W_DEF-1:0] rd;
    } ctrl_t;

    // A flushed stage register loads this, so nothing downstream acts on it.
    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard detect between the ID and EX instructions; purely combinational.
// Latency 0; no backpressure of its own, the result feeds the stall decision.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    output logic                  lu
);

    always_comb begin
        lu = ex_is_load & ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                           (id_uses_rs2 & (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencer: stage enables, flushes, PC write, dmem req/ack wait, timeout error, stall count.
// Latency 0 (decisions combinational from state and inputs); dmem wait freezes every stage until ack.
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_is_access,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  en_if_id,
    output logic                  en_id_ex,
    output logic                  en_ex_mem,
    output logic                  en_mem_wb,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  pc_we,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              lu;
    logic              req_c, pc_we_c, fl_if_id_c, fl_id_ex_c;
    logic [3:0]        en_c;

    pipe_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .lu          (lu)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        req_c       = 1'b0;
        en_c        = 4'b0000;
        pc_we_c     = 1'b0;
        fl_if_id_c  = 1'b0;
        fl_id_ex_c  = 1'b0;

        case (state_q)
            RUN: begin
                req_c = mem_is_access;
                if (mem_is_access && !dmem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else if (ex_branch_taken) begin
                    en_c       = 4'b1111;
                    pc_we_c    = 1'b1;
                    fl_if_id_c = 1'b1;
                    fl_id_ex_c = 1'b1;
                end else if (lu) begin
                    // ID holds and re-issues next cycle; a bubble goes into ID/EX.
                    en_c       = 4'b0111;
                    fl_id_ex_c = 1'b1;
                end else begin
                    en_c    = 4'b1111;
                    pc_we_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                req_c = 1'b1;
                if (dmem_ack) begin
                    en_c       = 4'b1111;
                    pc_we_c    = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ERR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!pc_we_c && state_q != ERR && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Gating with rst_n drops the request at once when reset lands mid-access.
    assign dmem_req    = rst_n & req_c;
    assign en_if_id    = rst_n & en_c[3];
    assign en_id_ex    = rst_n & en_c[2];
    assign en_ex_mem   = rst_n & en_c[1];
    assign en_mem_wb   = rst_n & en_c[0];
    assign flush_if_id = rst_n & fl_if_id_c;
    assign flush_id_ex = rst_n & fl_id_ex_c;
    assign pc_we       = rst_n & pc_we_c;
    assign mem_err     = mem_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipe_stage_ctrl;

    localparam int RW      = 4;
    localparam int TMO     = 15;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
    logic          mem_is_access, dmem_ack;
    logic          dmem_req, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic          flush_if_id, flush_id_ex, pc_we, mem_err;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_is_access   (mem_is_access),
        .dmem_ack        (dmem_ack),
        .dmem_req        (dmem_req),
        .en_if_id        (en_if_id),
        .en_id_ex        (en_id_ex),
        .en_ex_mem       (en_ex_mem),
        .en_mem_wb       (en_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .pc_we           (pc_we),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. m_reqs counts request cycles already spent on the access
    // held in MEM (0 = none outstanding); m_err is the sticky timeout condition.
    int   m_reqs  = 0;
    bit   m_err   = 0;
    int   m_stall = 0;

    always @(negedge clk) begin
        logic [8:0] act_v, exp_v;
        logic       lu_m, stalled;
        act_v   = {dmem_req, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                   flush_if_id, flush_id_ex, pc_we, mem_err};
        exp_v   = '0;
        stalled = 1'b0;
        lu_m    = ex_is_load && ((id_uses_rs1 && id_rs1 == ex_rd) ||
                                 (id_uses_rs2 && id_rs2 == ex_rd));
        if (!rst_n) begin
            m_reqs  = 0;
            m_err   = 0;
            m_stall = 0;
        end
        check("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (!rst_n) begin
            exp_v = '0;
        end else if (m_err) begin
            exp_v = 9'b0_0000_00_0_1;
        end else if (m_reqs > 0) begin
            if (dmem_ack) begin
                exp_v  = 9'b1_1111_00_1_0;
                m_reqs = 0;
            end else begin
                exp_v   = 9'b1_0000_00_0_0;
                stalled = 1'b1;
                if (m_reqs + 1 == TMO + 1) m_err = 1;
                else m_reqs = m_reqs + 1;
            end
        end else if (mem_is_access && !dmem_ack) begin
            exp_v   = 9'b1_0000_00_0_0;
            stalled = 1'b1;
            m_reqs  = 1;
        end else if (ex_branch_taken) begin
            exp_v = {mem_is_access, 8'b1111_11_1_0};
        end else if (lu_m) begin
            exp_v   = {mem_is_access, 8'b0111_01_0_0};
            stalled = 1'b1;
        end else begin
            exp_v = {mem_is_access, 8'b1111_00_1_0};
        end
        check("model_outputs", 32'(act_v), 32'(exp_v));
        if (stalled && m_stall < CNT_MAX) m_stall = m_stall + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0;
        ex_branch_taken = 0; mem_is_access = 0; dmem_ack = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick(); tick(); tick();
        check("reset_outputs_zero",
              32'({dmem_req, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                   flush_if_id, flush_id_ex, pc_we, mem_err}), 32'd0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);

        rst_n = 1'b1;
        tick(); #1;
        check("run_en_all", 32'({en_if_id, en_id_ex, en_ex_mem, en_mem_wb, pc_we}), 32'b11111);

        // Load-use on rs1
        tick();
        ex_is_load = 1; ex_rd = 4'd5; id_uses_rs1 = 1; id_rs1 = 4'd5; #1;
        check("lu_en_if_id", 32'(en_if_id), 32'd0);
        check("lu_pc_we", 32'(pc_we), 32'd0);
        check("lu_flush_id_ex", 32'(flush_id_ex), 32'd1);
        check("lu_en_ex_mem_wb", 32'({en_ex_mem, en_mem_wb}), 32'b11);
        tick(); idle(); #1;
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Same registers, but rs1 not actually read
        tick();
        ex_is_load = 1; ex_rd = 4'd5; id_uses_rs1 = 0; id_rs1 = 4'd5;
        id_uses_rs2 = 1; id_rs2 = 4'd3; #1;
        check("no_lu_pc_we", 32'(pc_we), 32'd1);

        // Branch wins over simultaneous load-use
        tick();
        ex_branch_taken = 1; ex_is_load = 1; ex_rd = 4'd7; id_uses_rs2 = 1; id_rs2 = 4'd7; #1;
        check("br_flushes", 32'({flush_if_id, flush_id_ex}), 32'b11);
        check("br_en_pc", 32'({en_if_id, en_id_ex, en_ex_mem, en_mem_wb, pc_we}), 32'b11111);
        tick(); idle(); #1;
        check("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // Memory access acked in its 4th request cycle
        tick(); mem_is_access = 1; #1;
        check("mw_req_c1", 32'({dmem_req, pc_we}), 32'b10);
        tick(); tick();
        tick(); dmem_ack = 1; #1;
        check("mw_ack_c4", 32'({dmem_req, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, pc_we}), 32'b111111);
        tick(); idle(); #1;
        check("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        check("mw_back_run", 32'(pc_we), 32'd1);

        // Zero-wait access with a load-use: the load-use stall still applies
        tick(); mem_is_access = 1; dmem_ack = 1;
        ex_is_load = 1; ex_rd = 4'd2; id_uses_rs1 = 1; id_rs1 = 4'd2; #1;
        check("zw_lu", 32'({dmem_req, en_if_id, flush_id_ex, pc_we}), 32'b1010);
        tick(); idle(); #1;
        check("zw_stall_cnt", 32'(stall_cnt), 32'd5);

        // Timeout: 16 unacknowledged request cycles
        tick(); mem_is_access = 1;
        repeat (TMO) tick();
        #1;
        check("tmo_c16_req", 32'({dmem_req, mem_err}), 32'b10);
        tick(); #1;
        check("tmo_err", 32'({dmem_req, en_if_id, pc_we, mem_err}), 32'b0001);
        check("tmo_stall_cnt", 32'(stall_cnt), 32'd21);
        tick(); dmem_ack = 1; #1;
        check("err_ack_ignored", 32'({dmem_req, en_if_id, en_mem_wb, pc_we, mem_err}), 32'b00001);
        tick(); #1;
        check("err_stall_frozen", 32'(stall_cnt), 32'd21);

        // Reset pulse clears the error
        rst_n = 1'b0; #1;
        check("rst_clears_err", 32'({mem_err, stall_cnt}), 32'd0);
        tick(); rst_n = 1'b1; idle(); #1;
        check("post_rst_run", 32'({pc_we, mem_err}), 32'b10);

        // Ack on the 16th request cycle still succeeds
        tick(); mem_is_access = 1;
        repeat (TMO) tick();
        dmem_ack = 1; #1;
        check("ack_c16_ok", 32'({en_if_id, en_mem_wb, pc_we, mem_err}), 32'b1110);
        tick(); idle(); #1;
        check("ack_c16_stall", 32'({mem_err, stall_cnt}), 32'd15);

        // Reset during the second cycle of a wait
        tick(); mem_is_access = 1;
        tick(); #1;
        check("mid_wait_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0; #1;
        check("mid_wait_req_drop", 32'(dmem_req), 32'd0);
        tick(); rst_n = 1'b1; idle(); #1;
        check("mid_wait_run", 32'({pc_we, stall_cnt}), 32'h1_0000);
        check("mid_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Pipeline sequencing controller for the five-stage filter processor. It drives the load enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC write enable. It resolves three hazards: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits over a req/ack handshake. It also keeps a memory-timeout error flag and a stall performance counter.

## Interface
- REG_ADDR_W, 4: register index width; matches the 4-bit destination field carried down the pipe
- MEM_TIMEOUT, 15: extra unacknowledged wait cycles tolerated before error
- CNT_W, 16: stall counter width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the matching source is actually read
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
- ex_is_load  in  1  the instruction in EX is a data-memory load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_is_access  in  1  the instruction in MEM accesses data memory
- dmem_ack  in  1  data memory completes the access this cycle
- dmem_req  out  1  data-memory request
- en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1  stage register load enables
- flush_if_id, flush_id_ex  out  1  load a bubble (all control bits 0) into that register
- pc_we  out  1  PC update enable
- mem_err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- States: RUN, MEM_WAIT, ERR. Reset state is RUN, with wait_cnt = 0, stall_cnt = 0 and mem_err = 0.
- While rst_n = 0, every output is 0 asynchronously, including all enables, flushes, pc_we and dmem_req.
- Load-use hazard: lu = ex_is_load & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- dmem_req = mem_is_access in RUN; dmem_req = 1 in MEM_WAIT; dmem_req = 0 in ERR.
- RUN priority order, highest first:
  - mem_is_access & !dmem_ack: freeze. All en_* = 0, pc_we = 0, no flush. Next state MEM_WAIT, wait_cnt ← 1.
  - ex_branch_taken: all en_* = 1, flush_if_id = 1, flush_id_ex = 1, pc_we = 1. A simultaneous lu is ignored.
  - lu: en_if_id = 0, pc_we = 0, flush_id_ex = 1, en_ex_mem = 1, en_mem_wb = 1. This is a single bubble.
  - Otherwise: all en_* = 1, pc_we = 1, flushes 0.
  - mem_is_access & dmem_ack in the same cycle is a zero-wait access. No stall; the lower-priority rules apply.
- MEM_WAIT:
  - All en_* = 0, pc_we = 0.
  - On dmem_ack: all en_* = 1 and pc_we = 1 in that same cycle; next state RUN. Branch, lu and flush inputs are ignored in this cycle; flushes stay 0.
  - No ack and wait_cnt == MEM_TIMEOUT: next state ERR, mem_err ← 1.
  - No ack otherwise: wait_cnt ← wait_cnt + 1.
- ERR: all en_*, flushes, pc_we and dmem_req are 0. mem_err = 1. Only rst_n exits ERR.
- stall_cnt increments by 1 on each clock edge where pc_we = 0 and state ≠ ERR. It saturates at 2^CNT_W − 1 and never wraps.

## Timing
- All decisions are combinational from the current state and inputs. The stage registers act on the same clock edge.
- Load-use costs exactly 1 cycle. Branch costs 2 squashed instructions and 0 stall cycles.
- A memory access acknowledged in its k-th request cycle (k ≥ 1) costs k − 1 stall cycles.
- ERR is entered on the edge ending the (MEM_TIMEOUT + 1)-th consecutive unacknowledged request cycle. An ack in that cycle still succeeds.
- Reset asserted mid-MEM_WAIT: the access is abandoned and dmem_req drops immediately, without waiting for clk. After release the block is in RUN.
- dmem_ack while dmem_req = 0 is ignored.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERR)
  - REG_ADDR_W and CNT_W defaults
  - the bubble control-word constant (all zero) used by the stage registers
- Sub-module pipe_hazard_detect: purely combinational; computes lu from the ID/EX fields.
- State register, wait_cnt (width ceil(log2(MEM_TIMEOUT + 1))), mem_err and stall_cnt live in the top module.

## Test plan
- Reset: hold rst_n = 0 → all outputs 0, stall_cnt = 0. Release with idle inputs → en_* = 1, pc_we = 1 next cycle.
- Load-use: ex_is_load = 1, ex_rd = 5, id_uses_rs1 = 1, id_rs1 = 5 for one cycle → en_if_id = 0, pc_we = 0, flush_id_ex = 1, en_ex_mem = en_mem_wb = 1; stall_cnt = 1 afterwards. Repeat with id_uses_rs1 = 0 → no stall.
- Branch with simultaneous lu → flush_if_id = flush_id_ex = 1, pc_we = 1, all en_* = 1; stall_cnt unchanged.
- Memory wait: mem_is_access = 1, dmem_ack first in the 4th request cycle → dmem_req high for 4 cycles, freeze for 3, all enables 1 in the 4th; stall_cnt += 3; state RUN.
- Timeout (MEM_TIMEOUT = 15): no ack → ERR after 16 request cycles, mem_err = 1, dmem_req = 0, enables 0. A later ack has no effect. rst_n pulse clears mem_err.
- Reset mid-MEM_WAIT (cycle 2 of the wait) → dmem_req falls before the next clk edge. After release: RUN, wait_cnt = 0, stall_cnt = 0.
